cim_weight_loader: RTL and testbench
====================================

Name: cim_weight_loader

Overview:
- Initiator side of the CIM array write interface: turns an upstream valid/ready stream of 24-bit weight words into the one-hot row-write transactions (D, WA, cima) that the array write controller consumes.
- One burst loads ROWS consecutive rows into the array bank selected at start (cima=1 → array 0, cima=0 → array 1).
- Sits between the weight buffer / DMA and the CIM array write controller.

Parameters:
- DW, 24, data word width; equals the array row width and the D bus width.
- ROWS, 8, rows per burst; also the WA width (one bit per row).

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- start  input  1  single-cycle burst request; sampled only in IDLE
- bank  input  1  target bank captured with start; driven onto cima
- abort  input  1  terminates the burst in progress
- s_valid  input  1  upstream word valid
- s_data  input  DW  upstream weight word
- s_ready  output  1  loader accepts a word this cycle
- D  output  DW  row data to the array controller
- WA  output  ROWS  one-hot row write strobe; all-zero means no write
- cima  output  1  bank select to the array controller
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse when the final row is issued

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, row counter=0, D=0, WA=0, cima=0, busy=0, done=0, s_ready=0.
- All outputs are registered except s_ready, which is combinational: s_ready = (state==LOAD) && !abort.
- States: IDLE, LOAD, DONE.
- IDLE:
  - start=1 && abort=0 → LOAD next cycle; capture bank into cima; row=0; busy=1.
  - start=1 && abort=1 in the same cycle → stay IDLE; cima is not updated.
- LOAD, word accepted (s_valid && s_ready):
  - Next cycle D=s_data and WA has exactly bit[row] set, for exactly one cycle; row increments.
  - Latency is 1 cycle from accept to the write strobe on WA.
- LOAD, no accept: WA=0 and D holds its last value. The downstream controller ignores WA==0, so a stalled upstream produces no writes.
- Last row: on acceptance with row==ROWS-1 → DONE. The final WA strobe and done=1 appear in the same cycle. The row counter does not wrap inside a burst.
- DONE: lasts 1 cycle; → IDLE; busy=0 from the following cycle. A start sampled in DONE is ignored.
- start while busy (LOAD or DONE) is ignored. bank changes while busy are ignored.
- abort in LOAD:
  - abort has priority over a coincident accept: the word is not consumed and no WA strobe follows.
  - → IDLE next cycle; WA=0; busy=0; done never asserts; rows already written are not rolled back.
  - The row counter clears on the next start.
- abort in IDLE or DONE has no effect beyond blocking a same-cycle start.
- cima is constant for the entire burst and holds its value after the burst, so the controller never sees a bank flip while WA≠0.
- WA is never multi-hot. Rows are issued in ascending order, bit 0 first.
- Reset mid-burst: all outputs return to reset values immediately; the partial burst is dropped.

Test Plan:
- Back-to-back burst: start, bank=1, s_valid held high, data 0x000001..0x000008 → WA=0x01,0x02,…,0x80 on 8 consecutive cycles, each 1 cycle after its accept; D tracks the data; cima=1 throughout; done=1 together with WA=0x80; busy drops the cycle after done.
- Stalled upstream: bank=0; s_valid toggles 1,0,0,1,… → WA=0 during gaps and D holds; 8 strobes total; cima=0; done after the 8th.
- Abort mid-burst: abort together with the 4th s_valid → only WA=0x01,0x02,0x04 were issued; s_ready=0 in the abort cycle; done stays 0; next burst starts at WA=0x01.
- Ignored requests: start pulses with bank toggling during LOAD → no restart; cima unchanged; exactly 8 strobes. start+abort together in IDLE → stays IDLE, busy=0.
- Reset mid-burst: rstn low after 3 rows → D=0, WA=0, cima=0, busy=0 immediately; after release, a fresh start writes from row 0.
- Protocol checks on every cycle: WA is zero or one-hot; cima is stable whenever busy=1; s_ready=1 only in LOAD.

Source files
------------

// File: rtl/cim_weight_loader.sv
// cim_weight_loader: turns a valid/ready weight stream into one-hot CIM row-write bursts.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   start, bank    burst request (IDLE only) and target bank captured with it
//   abort          terminates the burst in progress; wins over a same-cycle accept
//   s_valid/s_data/s_ready  upstream word stream; s_ready is combinational
//   D, WA, cima    registered row data, one-hot row strobe, bank select
//   busy, done     burst in progress, one-cycle pulse with the final row strobe
module cim_weight_loader #(
    parameter int DW   = 24,
    parameter int ROWS = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            bank,
    input  logic            abort,
    input  logic            s_valid,
    input  logic [DW-1:0]   s_data,
    output logic            s_ready,
    output logic [DW-1:0]   D,
    output logic [ROWS-1:0] WA,
    output logic            cima,
    output logic            busy,
    output logic            done
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t          state, state_n;
    logic [RW-1:0]   row, row_n;
    logic [DW-1:0]   d_n;
    logic [ROWS-1:0] wa_n;
    logic            cima_n, busy_n, done_n, accept, last;

    assign s_ready = (state == LOAD) && !abort;
    assign accept  = s_valid && s_ready;
    assign last    = row == RW'(ROWS - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            row   <= '0;
            D     <= '0;
            WA    <= '0;
            cima  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            row   <= row_n;
            D     <= d_n;
            WA    <= wa_n;
            cima  <= cima_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // WA and done default to zero so every strobe lasts exactly one cycle;
    // D and cima default to holding so a stall or finished burst leaves them steady.
    always_comb begin
        state_n = state;
        row_n   = row;
        d_n     = D;
        wa_n    = '0;
        cima_n  = cima;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: if (start && !abort) begin
                state_n = LOAD;
                row_n   = '0;
                cima_n  = bank;
                busy_n  = 1'b1;
            end
            LOAD: if (abort) begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end else if (accept) begin
                d_n     = s_data;
                wa_n    = ROWS'(1) << row;
                row_n   = last ? row : row + 1'b1;
                state_n = last ? DONE : LOAD;
                done_n  = last;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_cim_weight_loader.sv
// tb_cim_weight_loader: directed self-checking bench for cim_weight_loader.
module tb_cim_weight_loader;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0, bank = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [23:0] s_data = '0;
    logic        s_ready, cima, busy, done;
    logic [23:0] D;
    logic [7:0]  WA;
    int          checks = 0;
    int          errors = 0;
    logic        prev_busy = 1'b0, prev_cima = 1'b0;

    cim_weight_loader #(.DW(24), .ROWS(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .bank(bank), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .D(D), .WA(WA), .cima(cima), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic exp_cima);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_wa"}, 32'(WA), 32'd0);
        chk({tag, "_cima"}, 32'(cima), 32'(exp_cima));
        chk({tag, "_sready"}, 32'(s_ready), 32'd0);
    endtask

    // Protocol checks sampled mid-cycle on every clock.
    always @(negedge clk) begin
        if (rstn) begin
            chk("mon_onehot", 32'($onehot0(WA)), 32'd1);
            if (s_ready) chk("mon_sready_load", 32'(busy && !done), 32'd1);
            if (busy && prev_busy) chk("mon_cima_stable", 32'(cima), 32'(prev_cima));
        end
        prev_busy = busy;
        prev_cima = cima;
    end

    initial begin
        int k;
        logic [23:0] last_d;
        #1;
        chk_idle("rst_async", 1'b0);
        chk("rst_d", 32'(D), 32'd0);
        step();
        step();
        rstn = 1'b1;
        step();
        chk_idle("rst_rel", 1'b0);

        // Back-to-back burst into bank 1.
        start = 1'b1; bank = 1'b1;
        step();
        start = 1'b0; bank = 1'b0;
        chk("b1_busy", 32'(busy), 32'd1);
        chk("b1_cima", 32'(cima), 32'd1);
        chk("b1_wa0", 32'(WA), 32'd0);
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = 24'(i + 1);
            chk("b1_sready", 32'(s_ready), 32'd1);
            step();
            chk("b1_wa", 32'(WA), 32'(1 << i));
            chk("b1_d", 32'(D), 32'(i + 1));
            chk("b1_cima_run", 32'(cima), 32'd1);
            chk("b1_done", 32'(done), 32'(i == 7));
            chk("b1_busy_run", 32'(busy), 32'd1);
        end
        s_valid = 1'b0;
        step();
        chk_idle("b1_end", 1'b1);

        // Stalled upstream into bank 0: valid pattern 1,0,0,1,0,0,...
        start = 1'b1; bank = 1'b0;
        step();
        start = 1'b0; bank = 1'b1;
        chk("b2_cima", 32'(cima), 32'd0);
        k = 0;
        last_d = D;
        for (int c = 0; c < 40 && k < 8; c++) begin
            s_valid = (c % 3) == 0;
            s_data = 24'h100 + 24'(c);
            step();
            if ((c % 3) == 0) begin
                chk("b2_wa", 32'(WA), 32'(1 << k));
                last_d = 24'h100 + 24'(c);
                k++;
            end else begin
                chk("b2_wa_gap", 32'(WA), 32'd0);
            end
            chk("b2_d", 32'(D), 32'(last_d));
            chk("b2_done", 32'(done), 32'(k == 8 && (c % 3) == 0));
            chk("b2_cima_run", 32'(cima), 32'd0);
        end
        chk("b2_strobes", 32'(k), 32'd8);
        s_valid = 1'b0;
        step();
        chk_idle("b2_end", 1'b0);

        // Abort together with the 4th valid word.
        start = 1'b1; bank = 1'b1;
        step();
        start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 24'h31 + 24'(i);
            step();
            chk("ab_wa", 32'(WA), 32'(1 << i));
        end
        s_data = 24'h34;
        abort = 1'b1;
        #1;
        chk("ab_sready", 32'(s_ready), 32'd0);
        step();
        abort = 1'b0; s_valid = 1'b0;
        chk_idle("ab_end", 1'b1);
        chk("ab_d_hold", 32'(D), 32'h33);
        step();
        chk("ab_idle", 32'(busy), 32'd0);

        // Fresh burst restarts at row 0; start/bank pokes during LOAD are ignored.
        start = 1'b1; bank = 1'b1;
        step();
        start = 1'b0;
        s_valid = 1'b1;
        s_data = 24'h40;
        step();
        chk("ig_wa0", 32'(WA), 32'h01);
        chk("ig_d0", 32'(D), 32'h40);
        for (int i = 1; i < 8; i++) begin
            s_data = 24'h40 + 24'(i);
            start = i[0];
            bank = ~bank;
            step();
            chk("ig_wa", 32'(WA), 32'(1 << i));
            chk("ig_cima", 32'(cima), 32'd1);
            chk("ig_done", 32'(done), 32'(i == 7));
        end
        s_valid = 1'b0;
        start = 1'b1; bank = 1'b0;
        step();
        start = 1'b0;
        chk_idle("ig_done_start", 1'b1);
        step();
        chk("ig_still_idle", 32'(busy), 32'd0);

        // start together with abort in IDLE: no burst, cima untouched.
        start = 1'b1; abort = 1'b1; bank = 1'b0;
        step();
        start = 1'b0; abort = 1'b0;
        chk_idle("sa", 1'b1);
        step();
        chk("sa_busy2", 32'(busy), 32'd0);

        // Reset in the middle of a burst.
        start = 1'b1; bank = 1'b1;
        step();
        start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 24'h70 + 24'(i);
            step();
            chk("rs_wa", 32'(WA), 32'(1 << i));
        end
        rstn = 1'b0;
        #1;
        chk_idle("rs_async", 1'b0);
        chk("rs_d", 32'(D), 32'd0);
        s_valid = 1'b0;
        step();
        rstn = 1'b1;
        step();
        chk_idle("rs_rel", 1'b0);
        start = 1'b1; bank = 1'b0;
        step();
        start = 1'b0;
        s_valid = 1'b1;
        s_data = 24'h55;
        step();
        chk("rs_wa_fresh", 32'(WA), 32'h01);
        chk("rs_d_fresh", 32'(D), 32'h55);
        chk("rs_cima_fresh", 32'(cima), 32'd0);
        s_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("rs_abort", 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
